ib_transformer_up: RTL

//  Upstream half of the internal-bus width transformer: packs an 8-bit IB byte stream into 64-bit IB words.

---
 rtl/transformer_pkg.sv | 16 +
 rtl/ib_up_lane_assembler.sv | 47 ++++
 rtl/ib_transformer_up.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/transformer_pkg.sv
// Shared widths, lane indexing and FSM states for the IB width transformer.
package transformer_pkg;

    localparam int unsigned cUpDataWidth   = 64;
    localparam int unsigned cDownDataWidth = 8;
    localparam int unsigned cLanes         = cUpDataWidth / cDownDataWidth;
    localparam int unsigned cLaneIdxWidth  = $clog2(cLanes);

    typedef logic [cLaneIdxWidth-1:0] t_lane_idx;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PACK = 1'b1
    } t_up_state;

endpackage

// File: rtl/ib_up_lane_assembler.sv
// Byte-lane assembly register: decodes the lane write enable and presents the word
// including the byte written this cycle, with all lanes above it forced to zero.
module ib_up_lane_assembler
    import transformer_pkg::*;
#(
    parameter int unsigned LANE_WIDTH = cDownDataWidth,
    parameter int unsigned LANES      = cLanes
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    input  logic [$clog2(LANES)-1:0]      lane_i,
    input  logic [LANE_WIDTH-1:0]         data_i,
    input  logic                          clear_i,
    output logic [LANES*LANE_WIDTH-1:0]   word_c_o
);

    localparam int unsigned IDX_W = $clog2(LANES);

    logic [LANES*LANE_WIDTH-1:0] asm_q;
    logic [LANES*LANE_WIDTH-1:0] asm_d;
    logic [LANES-1:0]            lane_we;

    // Merge the incoming byte; clearing after a completed word keeps upper lanes zero.
    always_comb begin
        lane_we  = '0;
        word_c_o = asm_q;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_we[k] = wr_en_i && (lane_i == IDX_W'(k));
            if (lane_we[k]) begin
                word_c_o[k*LANE_WIDTH +: LANE_WIDTH] = data_i;
            end else if (wr_en_i && (IDX_W'(k) > lane_i)) begin
                word_c_o[k*LANE_WIDTH +: LANE_WIDTH] = '0;
            end
        end
        asm_d = clear_i ? '0 : word_c_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            asm_q <= '0;
        end else begin
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/ib_transformer_up.sv
// 8-bit to 64-bit IB packer with SOP/EOP framing and protocol-error detection.
// Optional statistics counters when IB_TRANSFORMER_UP_STATS_EN is defined.
module ib_transformer_up
    import transformer_pkg::*;
#(
    parameter int unsigned UP_DATA_WIDTH   = cUpDataWidth,
    parameter int unsigned DOWN_DATA_WIDTH = cDownDataWidth,
    parameter int unsigned OUTPUT_PIPE     = 0
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [DOWN_DATA_WIDTH-1:0]  IN_DATA,
    input  logic                        IN_SOP_N,
    input  logic                        IN_EOP_N,
    input  logic                        IN_SRC_RDY_N,
    output logic                        IN_DST_RDY_N,
    output logic [UP_DATA_WIDTH-1:0]    OUT_DATA,
    output logic                        OUT_SOP_N,
    output logic                        OUT_EOP_N,
    output logic                        OUT_SRC_RDY_N,
    input  logic                        OUT_DST_RDY_N,
    output logic                        ERR_PROTO
`ifdef IB_TRANSFORMER_UP_STATS_EN
    ,
    output logic [31:0]                 STAT_PKT_CNT,
    output logic [15:0]                 STAT_ERR_CNT
`endif
);

    localparam int unsigned LANES = UP_DATA_WIDTH / DOWN_DATA_WIDTH;
    localparam int unsigned IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

    t_up_state                 state_q;
    logic [IDX_W-1:0]          cnt_q;
    logic                      sop_pend_q;
    logic                      err_q;
    logic                      err_d;
    logic                      s1_valid_q;
    logic                      s1_sop_q;
    logic                      s1_eop_q;
    logic [UP_DATA_WIDTH-1:0]  s1_data_q;
    logic                      s1_dn_rdy;

    logic                      in_vld;
    logic                      in_sop;
    logic                      in_eop;
    logic                      out_can_load;
    logic                      flush_req;
    logic                      completes;
    logic                      in_rdy;
    logic                      in_acc;
    logic                      do_flush;
    logic                      load;
    logic                      load_sop;
    logic                      load_eop;
    logic                      asm_wr;
    logic                      asm_clear;
    logic [IDX_W-1:0]          asm_lane;
    logic [UP_DATA_WIDTH-1:0]  asm_word;

    ib_up_lane_assembler #(
        .LANE_WIDTH (DOWN_DATA_WIDTH),
        .LANES      (LANES)
    ) u_asm (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .wr_en_i  (asm_wr),
        .lane_i   (asm_lane),
        .data_i   (IN_DATA),
        .clear_i  (asm_clear),
        .word_c_o (asm_word)
    );

    // Handshake and word-completion decode; input stalls only when a word cannot be handed off.
    always_comb begin
        in_vld       = !IN_SRC_RDY_N;
        in_sop       = !IN_SOP_N;
        in_eop       = !IN_EOP_N;
        out_can_load = !s1_valid_q || s1_dn_rdy;
        flush_req    = (state_q == S_PACK) && in_vld && in_sop;
        completes    = in_vld && (((state_q == S_IDLE) && in_sop && in_eop) ||
                       ((state_q == S_PACK) && !in_sop && (in_eop || (cnt_q == LAST_LANE))));
        in_rdy       = !(flush_req || (!out_can_load &&
                       (completes || ((state_q == S_PACK) && (cnt_q == LAST_LANE)))));
        in_acc       = in_vld && in_rdy;
        do_flush     = flush_req && out_can_load;
        asm_wr       = 1'b0;
        asm_lane     = cnt_q;
        asm_clear    = 1'b0;
        load         = 1'b0;
        load_sop     = 1'b0;
        load_eop     = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                asm_lane = '0;
                if (in_acc) begin
                    if (in_sop) begin
                        asm_wr = 1'b1;
                        if (in_eop) begin
                            load      = 1'b1;
                            load_sop  = 1'b1;
                            load_eop  = 1'b1;
                            asm_clear = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PACK: begin
                if (do_flush) begin
                    load      = 1'b1;
                    load_sop  = sop_pend_q;
                    load_eop  = 1'b1;
                    asm_clear = 1'b1;
                    err_d     = 1'b1;
                end else if (in_acc) begin
                    asm_wr = 1'b1;
                    if (in_eop || (cnt_q == LAST_LANE)) begin
                        load      = 1'b1;
                        load_sop  = sop_pend_q;
                        load_eop  = in_eop;
                        asm_clear = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // FSM, lane counter and first output register; reloads in the cycle it drains.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sop_pend_q <= 1'b0;
            err_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            err_q <= err_d;
            case (state_q)
                S_IDLE: begin
                    if (in_acc && in_sop && !in_eop) begin
                        state_q    <= S_PACK;
                        cnt_q      <= IDX_W'(1);
                        sop_pend_q <= 1'b1;
                    end
                end
                S_PACK: begin
                    if (do_flush) begin
                        state_q    <= S_IDLE;
                        cnt_q      <= '0;
                        sop_pend_q <= 1'b0;
                    end else if (in_acc) begin
                        cnt_q <= cnt_q + IDX_W'(1);
                        if (load) begin
                            sop_pend_q <= 1'b0;
                        end
                        if (in_eop) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (load) begin
                s1_valid_q <= 1'b1;
                s1_data_q  <= asm_word;
                s1_sop_q   <= load_sop;
                s1_eop_q   <= load_eop;
            end else if (s1_dn_rdy) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    generate
        if (OUTPUT_PIPE != 0) begin : g_pipe
            logic                     p_valid_q;
            logic                     p_sop_q;
            logic                     p_eop_q;
            logic [UP_DATA_WIDTH-1:0] p_data_q;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    p_valid_q <= 1'b0;
                    p_sop_q   <= 1'b0;
                    p_eop_q   <= 1'b0;
                    p_data_q  <= '0;
                end else if (s1_valid_q && s1_dn_rdy) begin
                    p_valid_q <= 1'b1;
                    p_sop_q   <= s1_sop_q;
                    p_eop_q   <= s1_eop_q;
                    p_data_q  <= s1_data_q;
                end else if (!OUT_DST_RDY_N) begin
                    p_valid_q <= 1'b0;
                end
            end

            assign s1_dn_rdy     = !p_valid_q || !OUT_DST_RDY_N;
            assign OUT_DATA      = p_data_q;
            assign OUT_SRC_RDY_N = !p_valid_q;
            assign OUT_SOP_N     = !(p_valid_q && p_sop_q);
            assign OUT_EOP_N     = !(p_valid_q && p_eop_q);
        end else begin : g_nopipe
            assign s1_dn_rdy     = !OUT_DST_RDY_N;
            assign OUT_DATA      = s1_data_q;
            assign OUT_SRC_RDY_N = !s1_valid_q;
            assign OUT_SOP_N     = !(s1_valid_q && s1_sop_q);
            assign OUT_EOP_N     = !(s1_valid_q && s1_eop_q);
        end
    endgenerate

    assign IN_DST_RDY_N = !in_rdy;
    assign ERR_PROTO    = err_q;

`ifdef IB_TRANSFORMER_UP_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [15:0] err_cnt_q;

    // Packets counted as EOP words leave the block.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (!OUT_SRC_RDY_N && !OUT_DST_RDY_N && !OUT_EOP_N) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if (err_q) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign STAT_PKT_CNT = pkt_cnt_q;
    assign STAT_ERR_CNT = err_cnt_q;
`endif

endmodule
